// File: rtl/i2c_mon_pkg.sv
// Shared I2C monitor definitions: filter defaults, bus state and event payload.
// Imported by the line filter and by the downstream i2c_monitor.
package i2c_mon_pkg;

  localparam int unsigned SYNC_STAGES_DEF   = 2;
  localparam int unsigned STABLE_CYCLES_DEF = 64;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_BUSY = 1'b1
  } bus_state_e;

  typedef struct packed {
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic rstart_det;
    logic stop_det;
  } line_evt_t;

  // Debounce counter width; it only has to hold STABLE_CYCLES-1.
  function automatic int unsigned cnt_width(input int unsigned stable);
    return (stable < 2) ? 1 : $clog2(stable);
  endfunction

endpackage

// File: rtl/i2c_debounce.sv
// Synchronizer plus debounce for one raw I2C pin; the level only moves after
// the synced pin has differed from it for STABLE_CYCLES consecutive clocks.
module i2c_debounce
  import i2c_mon_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o
);

  localparam int unsigned     CNT_W   = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   synced;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
  assign synced = sync_q[SYNC_STAGES-1];

  // Counter runs only while synced and filtered disagree; any agreement clears it.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (synced != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = synced;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      level_q <= 1'b1;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/i2c_line_filter.sv
// Filtered SDA/SCL levels with registered SCL edge and START/STOP condition
// pulses, plus bus-busy tracking.
module i2c_line_filter
  import i2c_mon_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic SDA_GPIO,
  input  logic SCL_GPIO,
  output logic sda_f,
  output logic scl_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic rstart_det,
  output logic stop_det,
  output logic bus_busy
);

  logic       sda_lvl, scl_lvl;
  logic       sda_prev_q, scl_prev_q;
  logic       sda_chg, scl_chg;
  bus_state_e state_q, state_d;
  line_evt_t  evt_q, evt_d;

  i2c_debounce #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_sda_filt (
    .clk    (clk),
    .rst_n  (rst),
    .pin_i  (SDA_GPIO),
    .level_o(sda_lvl)
  );

  i2c_debounce #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_scl_filt (
    .clk    (clk),
    .rst_n  (rst),
    .pin_i  (SCL_GPIO),
    .level_o(scl_lvl)
  );

  assign sda_chg = sda_lvl ^ sda_prev_q;
  assign scl_chg = scl_lvl ^ scl_prev_q;

  // Conditions need SDA to move under a steady-high SCL; a coincident SCL edge wins.
  always_comb begin
    state_d          = state_q;
    evt_d            = '0;
    evt_d.scl_rise   = scl_lvl & ~scl_prev_q;
    evt_d.scl_fall   = ~scl_lvl & scl_prev_q;
    if (sda_chg && !scl_chg && scl_lvl) begin
      if (!sda_lvl) begin
        if (state_q == BUS_IDLE) begin
          evt_d.start_det = 1'b1;
          state_d         = BUS_BUSY;
        end else begin
          evt_d.rstart_det = 1'b1;
        end
      end else begin
        evt_d.stop_det = 1'b1;
        state_d        = BUS_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sda_prev_q <= 1'b1;
      scl_prev_q <= 1'b1;
      state_q    <= BUS_IDLE;
      evt_q      <= '0;
    end else begin
      sda_prev_q <= sda_lvl;
      scl_prev_q <= scl_lvl;
      state_q    <= state_d;
      evt_q      <= evt_d;
    end
  end

  assign sda_f      = sda_lvl;
  assign scl_f      = scl_lvl;
  assign scl_rise   = evt_q.scl_rise;
  assign scl_fall   = evt_q.scl_fall;
  assign start_det  = evt_q.start_det;
  assign rstart_det = evt_q.rstart_det;
  assign stop_det   = evt_q.stop_det;
  assign bus_busy   = (state_q == BUS_BUSY);

endmodule

// File: tb/tb_i2c_line_filter.sv
// Scoreboard bench for i2c_line_filter: stimulus queues expected pulses with
// their cycle stamps, a monitor pops and compares whenever any pulse fires.
module tb_i2c_line_filter;

  // Pin edge after clock N -> filtered change at N+66 -> pulse visible at N+67.
  localparam int LAT = 67;

  localparam logic [4:0] M_RISE   = 5'b00001;
  localparam logic [4:0] M_FALL   = 5'b00010;
  localparam logic [4:0] M_START  = 5'b00100;
  localparam logic [4:0] M_RSTART = 5'b01000;
  localparam logic [4:0] M_STOP   = 5'b10000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sda_pin = 1'b1;
  logic scl_pin = 1'b1;
  logic sda_f, scl_f, scl_rise, scl_fall, start_det, rstart_det, stop_det, bus_busy;

  typedef struct {
    int         cyc;
    logic [4:0] mask;
    logic       sda;
    logic       busy;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  i2c_line_filter dut (
    .clk       (clk),
    .rst       (rst),
    .SDA_GPIO  (sda_pin),
    .SCL_GPIO  (scl_pin),
    .sda_f     (sda_f),
    .scl_f     (scl_f),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .rstart_det(rstart_det),
    .stop_det  (stop_det),
    .bus_busy  (bus_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] outs();
    return {sda_f, scl_f, scl_rise, scl_fall, start_det, rstart_det, stop_det, bus_busy};
  endfunction

  function automatic void push(input int c, input logic [4:0] m, input logic s, input logic b);
    exp_t e;
    e.cyc  = c;
    e.mask = m;
    e.sda  = s;
    e.busy = b;
    sb_q.push_back(e);
  endfunction

  task automatic check_lvl(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pin(input bit is_scl, input logic v);
    if (is_scl) scl_pin = v;
    else        sda_pin = v;
  endtask

  // nb rejected 50-clock excursions to the new level, then the clean edge at cycle k.
  task automatic edge_phase(input bit is_scl, input logic v, input int nb, output int k);
    for (int b = 0; b < nb; b++) begin
      set_pin(is_scl, v);
      wait_cyc(50);
      set_pin(is_scl, ~v);
      wait_cyc(10);
    end
    set_pin(is_scl, v);
    k = cyc;
  endtask

  task automatic run_monitor();
    exp_t       e;
    logic [4:0] m;
    forever begin
      @(negedge clk);
      m = {stop_det, rstart_det, start_det, scl_fall, scl_rise};
      if (m != 5'b0) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: cycle %0d mask %b sda_f %b busy %b, expected no pulse",
                   cyc, m, sda_f, bus_busy);
        end else begin
          e = sb_q.pop_front();
          if (e.cyc != cyc || e.mask !== m || e.sda !== sda_f || e.busy !== bus_busy) begin
            n_fail++;
            $display("FAIL pulse: got cycle %0d mask %b sda_f %b busy %b, expected cycle %0d mask %b sda_f %b busy %b",
                     cyc, m, sda_f, bus_busy, e.cyc, e.mask, e.sda, e.busy);
          end
        end
      end
    end
  endtask

  initial begin
    int         k;
    int         nb;
    logic       b;
    logic       sda_cur;
    logic [7:0] data_byte;

    fork
      run_monitor();
    join_none

    // reset state and quiet release with both lines high
    #2 rst = 1'b0;
    wait_cyc(3);
    check_lvl("reset_outputs", outs(), 8'b1100_0000);
    rst = 1'b1;
    wait_cyc(100);
    check_lvl("idle_after_release", outs(), 8'b1100_0000);

    // 50-clock SDA glitch is rejected
    sda_pin = 1'b0;
    wait_cyc(50);
    sda_pin = 1'b1;
    wait_cyc(150);
    check_lvl("bounce_rejected", outs(), 8'b1100_0000);

    // START from idle
    edge_phase(1'b0, 1'b0, 0, k);
    push(k + LAT, M_START, 1'b0, 1'b1);
    wait_cyc(200);
    check_lvl("busy_after_start", outs(), 8'b0100_0001);

    // byte 0xAB, LSB first, with bounces on every edge
    data_byte = 8'hAB;
    sda_cur   = 1'b0;
    edge_phase(1'b1, 1'b0, 2, k);
    push(k + LAT, M_FALL, sda_cur, 1'b1);
    wait_cyc(200);
    for (int i = 0; i < 8; i++) begin
      b  = data_byte[i];
      nb = (i % 3) + 1;
      if (b != sda_cur) begin
        edge_phase(1'b0, b, nb, k);
        sda_cur = b;
      end
      wait_cyc(200);
      edge_phase(1'b1, 1'b1, nb, k);
      push(k + LAT, M_RISE, b, 1'b1);
      wait_cyc(200);
      edge_phase(1'b1, 1'b0, 1, k);
      push(k + LAT, M_FALL, b, 1'b1);
      wait_cyc(200);
    end

    // repeated START while busy, then STOP
    edge_phase(1'b1, 1'b1, 1, k);
    push(k + LAT, M_RISE, 1'b1, 1'b1);
    wait_cyc(200);
    edge_phase(1'b0, 1'b0, 1, k);
    push(k + LAT, M_RSTART, 1'b0, 1'b1);
    wait_cyc(200);
    check_lvl("busy_after_rstart", outs(), 8'b0100_0001);
    edge_phase(1'b0, 1'b1, 2, k);
    push(k + LAT, M_STOP, 1'b1, 1'b0);
    wait_cyc(200);
    check_lvl("idle_after_stop", outs(), 8'b1100_0000);

    // both pins move on the same clock: SCL edge only, no condition
    sda_pin = 1'b0;
    scl_pin = 1'b0;
    k = cyc;
    push(k + LAT, M_FALL, 1'b0, 1'b0);
    wait_cyc(200);
    check_lvl("simultaneous_fall", outs(), 8'b0000_0000);
    sda_pin = 1'b1;
    scl_pin = 1'b1;
    k = cyc;
    push(k + LAT, M_RISE, 1'b1, 1'b0);
    wait_cyc(200);
    check_lvl("simultaneous_rise", outs(), 8'b1100_0000);

    // reset three clocks after START
    edge_phase(1'b0, 1'b0, 0, k);
    push(k + LAT, M_START, 1'b0, 1'b1);
    wait_cyc(LAT + 3);
    check_lvl("busy_before_reset", outs(), 8'b0100_0001);
    rst = 1'b0;
    #1;
    check_lvl("mid_transfer_reset", outs(), 8'b1100_0000);
    sda_pin = 1'b1;
    wait_cyc(5);
    rst = 1'b1;
    wait_cyc(200);
    check_lvl("quiet_after_reset", outs(), 8'b1100_0000);

    check_lvl("scoreboard_drained", 8'(sb_q.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
